pc_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer that owns the program counter and issues instruction reads to the instruction-memory port through a request/address-ok/data-ok handshake.
- Keeps at most one read outstanding and applies redirects (exception, then branch from mem stage) with fixed priority.
- Discards stale returns after a redirect and presents fetched {pc, inst} to the IF/ID register with a valid/ready handshake.
- Sits between the mem-stage redirect logic and the IF/ID pipeline register, replacing the free-running pc+4 register.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_redirect_sel.sv | 35 +++
 rtl/pc_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch sequencer: reset/exception PCs, fetch state
// encoding and the redirect-source encoding that mem-stage logic also uses.
package pc_pkg;

    localparam logic [31:0] PC_INITIAL_DEFAULT = 32'hbfc00000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;
    localparam logic [31:0] PC_STEP            = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_EXC  = 2'd1,
        REDIR_BR   = 2'd2
    } redirect_src_e;

endpackage

// File: rtl/pc_redirect_sel.sv
// Fixed-priority redirect mux: an exception always wins over a mem-stage branch.
module pc_redirect_sel
    import pc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        exc_valid,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        redirect,
    output logic [31:0] new_pc
);

    redirect_src_e src_s;

    // Encode the winning source, then derive the redirect strobe and target.
    always_comb begin
        src_s  = REDIR_NONE;
        new_pc = 32'h0000_0000;
        if (exc_valid) begin
            src_s = REDIR_EXC;
        end else if (br_valid) begin
            src_s = REDIR_BR;
        end else begin
            src_s = REDIR_NONE;
        end
        case (src_s)
            REDIR_EXC: new_pc = EXC_VECTOR;
            REDIR_BR:  new_pc = br_target;
            default:   new_pc = 32'h0000_0000;
        endcase
        redirect = (src_s != REDIR_NONE);
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, keeps one instruction read in flight and
// feeds the IF/ID slot. Optional misaligned-PC trap under PC_FETCH_ALIGN_CHECK_EN.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter logic [31:0] PC_INITIAL = PC_INITIAL_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
`ifdef PC_FETCH_ALIGN_CHECK_EN
    output logic        if_adel,
`endif
    input  logic        id_ready,
    output logic [31:0] pc_cur
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r;
    logic         cancel_r;
    logic         if_valid_r;
    logic [31:0]  if_pc_r;
    logic [31:0]  if_inst_r;
    logic         redirect_s;
    logic [31:0]  new_pc_s;
    logic         inst_req_s;
    logic         capture_s;
    logic         outstanding_s;
    logic         slot_free_s;
    logic         misalign_s;
    logic         adel_cap_s;

    pc_redirect_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_sel (
        .exc_valid (exc_valid),
        .br_valid  (br_valid),
        .br_target (br_target),
        .redirect  (redirect_s),
        .new_pc    (new_pc_s)
    );

    assign slot_free_s = !if_valid_r || id_ready;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic if_adel_r;
    logic adel_done_r;
    assign misalign_s = (pc_r[1:0] != 2'b00);
    // A misaligned PC is reported once into the slot, then fetch parks until redirected.
    assign adel_cap_s = (state_r == REQ) && misalign_s && slot_free_s && !redirect_s && !adel_done_r;
    assign if_adel    = if_adel_r;
`else
    assign misalign_s = 1'b0;
    assign adel_cap_s = 1'b0;
`endif

    // Next-state, request strobe and capture decision.
    always_comb begin
        state_nxt_s   = state_r;
        inst_req_s    = 1'b0;
        capture_s     = 1'b0;
        outstanding_s = 1'b0;
        case (state_r)
            IDLE: begin
                state_nxt_s = REQ;
            end
            REQ: begin
                inst_req_s    = slot_free_s && !redirect_s && !misalign_s;
                outstanding_s = inst_req_s && inst_addr_ok;
                if (outstanding_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                outstanding_s = 1'b1;
                if (inst_data_ok) begin
                    state_nxt_s = REQ;
                    capture_s   = !cancel_r && !redirect_s;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, PC and cancel tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            pc_r     <= PC_INITIAL;
            cancel_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (redirect_s) begin
                pc_r <= new_pc_s;
            end else if (capture_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            // A return that completes in the redirect cycle needs no pending cancel.
            if (state_r == WAIT && inst_data_ok) begin
                cancel_r <= 1'b0;
            end else if (redirect_s && outstanding_s) begin
                cancel_r <= 1'b1;
            end
        end
    end

    // IF/ID output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_inst_r  <= 32'h0000_0000;
        end else if (redirect_s) begin
            if_valid_r <= 1'b0;
        end else if (capture_s) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= pc_r;
            if_inst_r  <= inst_rdata;
        end else if (adel_cap_s) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= pc_r;
            if_inst_r  <= 32'h0000_0000;
        end else if (id_ready) begin
            if_valid_r <= 1'b0;
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    // Address-error flag travels with the slot; done-flag blocks repeat reports.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_adel_r   <= 1'b0;
            adel_done_r <= 1'b0;
        end else if (redirect_s) begin
            if_adel_r   <= 1'b0;
            adel_done_r <= 1'b0;
        end else if (capture_s) begin
            if_adel_r <= 1'b0;
        end else if (adel_cap_s) begin
            if_adel_r   <= 1'b1;
            adel_done_r <= 1'b1;
        end
    end
`endif

    assign inst_req  = inst_req_s;
    assign inst_addr = inst_req_s ? pc_r : 32'h0000_0000;
    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_inst   = if_inst_r;
    assign pc_cur    = pc_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; the align-error scenario runs
// only when PC_FETCH_ALIGN_CHECK_EN is defined.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid, br_valid;
    logic [31:0] br_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic        id_ready;
    logic [31:0] pc_cur;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic        if_adel;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .exc_valid    (exc_valid),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
`ifdef PC_FETCH_ALIGN_CHECK_EN
        .if_adel      (if_adel),
`endif
        .id_ready     (id_ready),
        .pc_cur       (pc_cur)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; exc_valid = 1'b0; br_valid = 1'b0; br_target = 32'h0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0; id_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc_cur, 32'hbfc00000);
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_addr", inst_addr, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);

        next_cycle(); reset = 1'b0;                         // IDLE
        @(negedge clk); chk("idle_req", {31'd0, inst_req}, 32'd0);

        next_cycle();                                       // REQ, memory stalls addr_ok
        @(negedge clk);
        chk("req0_req", {31'd0, inst_req}, 32'd1);
        chk("req0_addr", inst_addr, 32'hbfc00000);
        next_cycle(); inst_addr_ok = 1'b1;                  // still REQ, accepted
        @(negedge clk); chk("req0b_addr", inst_addr, 32'hbfc00000);
        next_cycle(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
        @(negedge clk); chk("wait0_req", {31'd0, inst_req}, 32'd0);

        next_cycle(); inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("cap0_valid", {31'd0, if_valid}, 32'd1);
        chk("cap0_pc", if_pc, 32'hbfc00000);
        chk("cap0_inst", if_inst, 32'h11111111);
        chk("req1_addr", inst_addr, 32'hbfc00004);
        next_cycle(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h22222222;
        @(negedge clk);
        chk("wait1_valid", {31'd0, if_valid}, 32'd0);
        chk("wait1_req", {31'd0, inst_req}, 32'd0);
        next_cycle(); inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("req2_addr", inst_addr, 32'hbfc00008);
        chk("cap1_pc", if_pc, 32'hbfc00004);
        chk("cap1_inst", if_inst, 32'h22222222);

        // Branch while waiting; stale return two cycles later must be dropped.
        next_cycle(); inst_addr_ok = 1'b0; br_valid = 1'b1; br_target = 32'h80001000;
        @(negedge clk); chk("br_pc_before", pc_cur, 32'hbfc00008);
        next_cycle(); br_valid = 1'b0;
        @(negedge clk);
        chk("br_pc_after", pc_cur, 32'h80001000);
        chk("br_wait_req", {31'd0, inst_req}, 32'd0);
        next_cycle(); inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
        @(negedge clk); chk("stale_req", {31'd0, inst_req}, 32'd0);
        next_cycle(); inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("stale_valid", {31'd0, if_valid}, 32'd0);
        chk("br_req_addr", inst_addr, 32'h80001000);
        chk("br_pc_nostep", pc_cur, 32'h80001000);
        next_cycle(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h33333333;
        next_cycle(); inst_data_ok = 1'b0; id_ready = 1'b0;

        // Exception and branch together: exception wins, slot flushed.
        exc_valid = 1'b1; br_valid = 1'b1; br_target = 32'h80002000; inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("exc_pre_valid", {31'd0, if_valid}, 32'd1);
        chk("exc_pre_pc", if_pc, 32'h80001000);
        chk("exc_cyc_req", {31'd0, inst_req}, 32'd0);
        next_cycle(); exc_valid = 1'b0; br_valid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        chk("exc_flush", {31'd0, if_valid}, 32'd0);
        chk("exc_addr", inst_addr, 32'hbfc00380);
        next_cycle(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h44444444;
        id_ready = 1'b0;

        // Consumer stalls for 5 cycles; the slot must hold and no request issue.
        next_cycle(); inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, inst_req}, 32'd0);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'hbfc00380);
            chk("stall_inst", if_inst, 32'h44444444);
            if (i < 4) next_cycle();
        end
        next_cycle(); id_ready = 1'b1;
        @(negedge clk);
        chk("release_req", {31'd0, inst_req}, 32'd1);
        chk("release_addr", inst_addr, 32'hbfc00384);

        // Reset in WAIT, return arrives while IDLE and is ignored.
        next_cycle(); inst_addr_ok = 1'b0; reset = 1'b1;
        next_cycle(); reset = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h55555555;
        @(negedge clk);
        chk("rst2_req", {31'd0, inst_req}, 32'd0);
        chk("rst2_pc", pc_cur, 32'hbfc00000);
        next_cycle(); inst_data_ok = 1'b0;
        @(negedge clk);
        chk("rst2_valid", {31'd0, if_valid}, 32'd0);
        chk("rst2_addr", inst_addr, 32'hbfc00000);

        // PC wrap at the top of the address space.
        br_valid = 1'b1; br_target = 32'hfffffffc;
        next_cycle(); br_valid = 1'b0; inst_addr_ok = 1'b1;
        @(negedge clk); chk("wrap_addr", inst_addr, 32'hfffffffc);
        next_cycle(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h66666666;
        next_cycle(); inst_data_ok = 1'b0;
        @(negedge clk);
        chk("wrap_pc", pc_cur, 32'h00000000);
        chk("wrap_if_pc", if_pc, 32'hfffffffc);

`ifdef PC_FETCH_ALIGN_CHECK_EN
        br_valid = 1'b1; br_target = 32'h80000002;
        next_cycle(); br_valid = 1'b0; inst_addr_ok = 1'b1;
        @(negedge clk); chk("adel_req", {31'd0, inst_req}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("adel_req2", {31'd0, inst_req}, 32'd0);
        chk("adel_valid", {31'd0, if_valid}, 32'd1);
        chk("adel_flag", {31'd0, if_adel}, 32'd1);
        chk("adel_pc", if_pc, 32'h80000002);
        chk("adel_inst", if_inst, 32'h0);
        inst_addr_ok = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
